mem_bus_responder: RTL and testbench

- Single-port, word-addressed SRAM responder for the core/cache memory bus, i.e. the target side of the req/gnt/rvalid protocol that the set-associative cache drives on its memory port.
- Serves one transaction at a time.
- Grant and response latencies are configurable to exercise cache miss and write-through paths.
- Decodes an address window, applies byte-enabled writes, and flags out-of-window accesses.

---
 rtl/mem_bus_responder.sv | 116 +++++++++++
 tb/tb_mem_bus_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Word-addressed SRAM target for the req/gnt/rvalid memory bus: one transaction at a
// time, programmable grant and response latency, byte-enabled writes, window decode.
module mem_bus_responder #(
    parameter int unsigned MEM_WORDS_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR      = 32'h0010_0000,
    parameter int unsigned GNT_DELAY      = 1,
    parameter int unsigned RVALID_DELAY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned WORDS     = 1 << MEM_WORDS_LOG2;
    localparam logic [31:0] WIN_BYTES = 32'(4 * WORDS);
    localparam logic [3:0]  GNT_CTR0  = 4'(GNT_DELAY - 1);
    localparam logic [3:0]  RSP_CTR0  = 4'(RVALID_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_WAIT,
        RESP_WAIT
    } state_e;

    state_e                    state_q;
    logic [3:0]                ctr_q;
    logic [31:0]               rdata_q;
    logic                      err_q;
    logic [31:0]               mem_q [WORDS];

    logic [31:0]               offset;
    logic                      in_win;
    logic [MEM_WORDS_LOG2-1:0] idx;
    logic                      grant;

    // An address below BASE_ADDR wraps to a huge offset, so one compare covers both edges.
    assign offset = {addr_i[31:2], 2'b00} - BASE_ADDR;
    assign in_win = offset < WIN_BYTES;
    assign idx    = offset[MEM_WORDS_LOG2+1:2];

    assign grant    = (state_q == GRANT_WAIT) && (ctr_q == 4'd0) && req_i;
    assign gnt_o    = grant;
    assign rvalid_o = (state_q == RESP_WAIT) && (ctr_q == 4'd0);
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctr_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        state_q <= GRANT_WAIT;
                        ctr_q   <= GNT_CTR0;
                    end
                end
                GRANT_WAIT: begin
                    if (!req_i) begin
                        state_q <= IDLE;
                    end else if (ctr_q != 4'd0) begin
                        ctr_q <= ctr_q - 4'd1;
                    end else begin
                        state_q <= RESP_WAIT;
                        ctr_q   <= RSP_CTR0;
                    end
                end
                RESP_WAIT: begin
                    if (ctr_q != 4'd0) begin
                        ctr_q <= ctr_q - 4'd1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // The response is captured at the grant edge and held until the next grant.
            if (grant) begin
                if (!in_win) begin
                    rdata_q <= 32'd0;
                    err_q   <= 1'b1;
                end else if (we_i) begin
                    rdata_q <= 32'd0;
                    err_q   <= 1'b0;
                end else begin
                    rdata_q <= mem_q[idx];
                    err_q   <= 1'b0;
                end
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (grant && we_i && in_win) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: two instances (default latencies and 3/4), a word-level
// memory model with expected grant/response cycles, directed cases and random traffic.
module tb_mem_bus_responder;

    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam logic [31:0] WIN  = 32'd16384;

    logic        clk = 1'b0;
    logic        rst_n  [2];
    logic        req    [2];
    logic [31:0] addr   [2];
    logic        we     [2];
    logic [3:0]  be     [2];
    logic [31:0] wdata  [2];
    logic        gnt    [2];
    logic        rvalid [2];
    logic [31:0] rdata  [2];
    logic        err    [2];

    always #5 clk = ~clk;

    mem_bus_responder u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req_i(req[0]), .addr_i(addr[0]), .we_i(we[0]),
        .be_i(be[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .err_o(err[0])
    );

    mem_bus_responder #(.GNT_DELAY(3), .RVALID_DELAY(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req_i(req[1]), .addr_i(addr[1]), .we_i(we[1]),
        .be_i(be[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .err_o(err[1])
    );

    function automatic int gdel(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int rdel(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_tot  = 0;

    // Expected transaction outcome per instance
    int          exp_g  [2];
    int          exp_r  [2];
    logic [31:0] exp_rd [2];
    logic        exp_er [2];
    bit          exp_kn [2];

    logic [31:0] mm [2][4096];
    bit          kn [2][4096];

    task automatic chk(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] want);
        n_tot++;
        if (got === want) n_pass++;
        else $display("FAIL %s dut%0d: got %h want %h at t=%0t", name, inst, got, want, $time);
    endtask

    task automatic model_issue(input int i, input logic [31:0] a, input logic w,
                               input logic [3:0] b, input logic [31:0] d);
        bit inw;
        int idx;
        inw = (a >= BASE) && (a < BASE + WIN);
        idx = int'((a - BASE) >> 2) & 4095;
        exp_er[i] = !inw;
        exp_rd[i] = 32'd0;
        exp_kn[i] = 1'b1;
        if (inw && !w) begin
            exp_rd[i] = mm[i][idx];
            exp_kn[i] = kn[i][idx];
        end
        if (inw && w) begin
            for (int k = 0; k < 4; k++)
                if (b[k]) mm[i][idx][8*k +: 8] = d[8*k +: 8];
            if (b == 4'hF) kn[i][idx] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("gnt", i, 32'(gnt[i]), 32'(cyc == exp_g[i]));
            chk("rvalid", i, 32'(rvalid[i]), 32'(cyc == exp_r[i]));
            if (rvalid[i] && cyc == exp_r[i]) begin
                chk("err", i, 32'(err[i]), 32'(exp_er[i]));
                if (exp_kn[i]) chk("rdata", i, rdata[i], exp_rd[i]);
            end
            if (!rst_n[i]) begin
                chk("rst_rdata", i, rdata[i], 32'd0);
                chk("rst_err", i, 32'(err[i]), 32'd0);
            end
        end
    end

    task automatic txn(input int i, input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d, input bit ext, input bit rst_mid,
                       output logic [31:0] rd, output logic er, output int gl, output int rl);
        int rc;
        int gc;
        bit seen;
        rd = 32'd0;
        er = 1'b0;
        gl = -1;
        rl = -1;
        @(posedge clk);
        #1;
        req[i] = 1'b1; addr[i] = a; we[i] = w; be[i] = b; wdata[i] = d;
        rc = cyc;
        exp_g[i] = rc + gdel(i);
        exp_r[i] = exp_g[i] + rdel(i);
        model_issue(i, a, w, b, d);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (gnt[i]) seen = 1'b1;
        end
        chk("gnt_seen", i, 32'(seen), 32'd1);
        gc = cyc;
        gl = gc - rc;
        @(posedge clk);
        #1;
        if (ext) begin
            @(posedge clk);
            #1;
        end
        req[i] = 1'b0; addr[i] = $urandom; we[i] = 1'($urandom); wdata[i] = $urandom;
        be[i] = 4'($urandom);
        if (rst_mid) begin
            rst_n[i] = 1'b0;
            exp_r[i] = -1;
            repeat (2) @(posedge clk);
            #1;
            rst_n[i] = 1'b1;
        end else begin
            seen = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                @(negedge clk);
                if (rvalid[i]) seen = 1'b1;
            end
            chk("rvalid_seen", i, 32'(seen), 32'd1);
            rl = cyc - gc;
            rd = rdata[i];
            er = err[i];
        end
    endtask

    task automatic abort_req(input int i, input logic [31:0] a, input logic [31:0] d,
                             input int n);
        @(posedge clk);
        #1;
        req[i] = 1'b1; addr[i] = a; we[i] = 1'b1; be[i] = 4'hF; wdata[i] = d;
        exp_g[i] = -1;
        exp_r[i] = -1;
        repeat (n) @(posedge clk);
        #1;
        req[i] = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    logic [31:0] rd;
    logic        er;
    int          gl;
    int          rl;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; req[i] = 1'b1; addr[i] = BASE; we[i] = 1'b1;
            be[i] = 4'hF; wdata[i] = 32'hFFFF_FFFF;
            exp_g[i] = -1; exp_r[i] = -1; exp_rd[i] = 32'd0; exp_er[i] = 1'b0; exp_kn[i] = 1'b0;
            for (int w = 0; w < 4096; w++) kn[i][w] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b1;
            req[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("idle_rdata", 0, rdata[0], 32'd0);
        chk("idle_err", 1, 32'(err[1]), 32'd0);

        // Default latencies: full write then read back
        txn(0, 32'h0010_0040, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, rd, er, gl, rl);
        chk("gnt_lat", 0, 32'(gl), 32'd1);
        chk("rv_lat", 0, 32'(rl), 32'd2);
        chk("wr_err", 0, 32'(er), 32'd0);
        txn(0, 32'h0010_0040, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, er, gl, rl);
        chk("rd_word", 0, rd, 32'hDEAD_BEEF);

        // Byte-enable merge
        txn(0, 32'h0010_0044, 1'b1, 4'hF, 32'h1122_3344, 1'b0, 1'b0, rd, er, gl, rl);
        txn(0, 32'h0010_0044, 1'b1, 4'b0101, 32'hAABB_CCDD, 1'b0, 1'b0, rd, er, gl, rl);
        txn(0, 32'h0010_0044, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, er, gl, rl);
        chk("be_merge", 0, rd, 32'h11BB_33DD);
        txn(0, 32'h0010_0044, 1'b1, 4'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, rd, er, gl, rl);
        txn(0, 32'h0010_0044, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, er, gl, rl);
        chk("be_zero", 0, rd, 32'h11BB_33DD);

        // Window edges and out-of-window aliasing onto word 0
        txn(0, BASE, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b0, rd, er, gl, rl);
        txn(0, 32'h0000_0000, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, er, gl, rl);
        chk("oow_rd_err", 0, 32'(er), 32'd1);
        chk("oow_rd_data", 0, rd, 32'd0);
        txn(0, 32'h0011_4000, 1'b1, 4'hF, 32'h0BAD_0BAD, 1'b0, 1'b0, rd, er, gl, rl);
        chk("oow_wr_err", 0, 32'(er), 32'd1);
        txn(0, BASE, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, er, gl, rl);
        chk("word0_intact", 0, rd, 32'hCAFE_F00D);
        txn(0, 32'h0010_3FFC, 1'b1, 4'hF, 32'h7777_1234, 1'b0, 1'b0, rd, er, gl, rl);
        chk("last_word_err", 0, 32'(er), 32'd0);
        txn(0, 32'h0010_3FFF, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, er, gl, rl);
        chk("last_word_rd", 0, rd, 32'h7777_1234);

        // Long latencies with a cache-style trailing request cycle
        txn(1, 32'h0010_0080, 1'b1, 4'hF, 32'h1234_5678, 1'b1, 1'b0, rd, er, gl, rl);
        chk("gnt_lat", 1, 32'(gl), 32'd3);
        chk("rv_lat", 1, 32'(rl), 32'd4);
        txn(1, 32'h0010_0080, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, rd, er, gl, rl);
        chk("rd_word", 1, rd, 32'h1234_5678);

        // Aborted requests leave memory untouched
        abort_req(0, 32'h0010_0040, 32'h0, 1);
        txn(0, 32'h0010_0040, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, er, gl, rl);
        chk("abort_keep", 0, rd, 32'hDEAD_BEEF);
        abort_req(1, 32'h0010_0080, 32'h0, 2);
        abort_req(1, 32'h0010_0080, 32'h0, 3);
        txn(1, 32'h0010_0080, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, er, gl, rl);
        chk("abort_keep", 1, rd, 32'h1234_5678);

        // Reset during the response wait: no rvalid, write already committed
        for (int i = 0; i < 2; i++) begin
            txn(i, 32'h0010_0048, 1'b1, 4'hF, 32'h5A5A_5A5A, 1'b0, 1'b1, rd, er, gl, rl);
            repeat (6) @(posedge clk);
            txn(i, 32'h0010_0048, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rd, er, gl, rl);
            chk("rst_mid_keep", i, rd, 32'h5A5A_5A5A);
        end

        // Random traffic over a pre-initialised pool plus out-of-window addresses
        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 32; w++)
                txn(i, BASE + 32'(4 * w), 1'b1, 4'hF, $urandom, 1'b0, 1'b0, rd, er, gl, rl);
        for (int n = 0; n < 300; n++) begin
            int          i;
            int          r;
            logic [31:0] a;
            i = n % 2;
            r = int'($urandom_range(0, 19));
            if (r < 16) a = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
            else if (r == 16) a = BASE - 32'(4 * $urandom_range(1, 64));
            else if (r == 17) a = BASE + WIN + 32'(4 * $urandom_range(0, 64));
            else if (r == 18) a = $urandom;
            else a = BASE + WIN - 32'(4 * $urandom_range(1, 4));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            if ($urandom_range(0, 19) == 0)
                abort_req(i, a, $urandom, int'($urandom_range(1, gdel(i))));
            else
                txn(i, a, 1'($urandom), 4'($urandom), $urandom, 1'($urandom), 1'b0,
                    rd, er, gl, rl);
        end

        repeat (8) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
